// File: rtl/nbody_frame_engine.sv
// nbody_frame_engine: once-per-frame N-body gravity integrator plus diamond sprite renderer.
// Optional macro NBODY_WRAP_EN: screen edges wrap instead of bouncing.
module nbody_frame_engine #(
   parameter int unsigned N_BODIES  = 3,
   parameter int unsigned COORD_W   = 10,
   parameter int unsigned VEL_W     = 8,
   parameter int unsigned NEAR_DIST = 40,
   parameter int unsigned FAR_DIST  = 300,
   parameter int unsigned VMAX      = 15,
   parameter int unsigned SPR_R     = 20,
   parameter int unsigned SPR_SUM   = 25,
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned SCREEN_H  = 480,
   localparam int unsigned ID_W     = (N_BODIES > 1) ? $clog2(N_BODIES) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic               load_en,
   input  logic [ID_W-1:0]    load_id,
   input  logic [COORD_W-1:0] load_x,
   input  logic [COORD_W-1:0] load_y,
   input  logic [VEL_W-1:0]   load_vx,
   input  logic [VEL_W-1:0]   load_vy,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   input  logic               video_active,
   output logic               busy,
   output logic               overrun,
   output logic               hit,
   output logic [ID_W-1:0]    hit_id,
   output logic [5:0]         rgb
);

   localparam logic signed [VEL_W:0]     VMAX_S  = (VEL_W+1)'(VMAX);
   localparam logic signed [COORD_W+1:0] EXT_X   = (COORD_W+2)'(SCREEN_W);
   localparam logic signed [COORD_W+1:0] EXT_Y   = (COORD_W+2)'(SCREEN_H);
   localparam logic [COORD_W+1:0]        NEAR_D  = (COORD_W+2)'(NEAR_DIST);
   localparam logic [COORD_W+1:0]        FAR_D   = (COORD_W+2)'(FAR_DIST);
   localparam logic [COORD_W:0]          SPR_R_U = (COORD_W+1)'(SPR_R);
   localparam logic [COORD_W+1:0]        SPR_S_U = (COORD_W+2)'(SPR_SUM);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PAIR, S_INTEG, S_COMMIT} state_t;

   state_t                    state_q, state_d;
   logic                      pend_q, pend_d;
   logic [ID_W-1:0]           pi_q, pi_d, pj_q, pj_d, bi_q, bi_d;
   logic [COORD_W-1:0]        work_x_q  [N_BODIES], work_x_d  [N_BODIES];
   logic [COORD_W-1:0]        work_y_q  [N_BODIES], work_y_d  [N_BODIES];
   logic signed [VEL_W-1:0]   work_vx_q [N_BODIES], work_vx_d [N_BODIES];
   logic signed [VEL_W-1:0]   work_vy_q [N_BODIES], work_vy_d [N_BODIES];
   logic [COORD_W-1:0]        disp_x_q  [N_BODIES], disp_x_d  [N_BODIES];
   logic [COORD_W-1:0]        disp_y_q  [N_BODIES], disp_y_d  [N_BODIES];
   logic signed [VEL_W-1:0]   acc_x_q   [N_BODIES], acc_x_d   [N_BODIES];
   logic signed [VEL_W-1:0]   acc_y_q   [N_BODIES], acc_y_d   [N_BODIES];
   logic                      busy_q, busy_d, overrun_q, overrun_d;
   logic                      hit_q, hit_d;
   logic [ID_W-1:0]           hit_id_q, hit_id_d;
   logic [5:0]                rgb_q, rgb_d;

   logic                      tick_ok_c;
   logic [COORD_W+1:0]        pd_c;
   logic signed [VEL_W-1:0]   pf_c, psx_c, psy_c;
   logic                      hit_any_c;
   logic [ID_W-1:0]           hit_idx_c;

   function automatic logic [COORD_W:0] absdiff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
      return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
   endfunction

   function automatic logic covers(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                   input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
      logic [COORD_W:0] ax, ay;
      ax = absdiff(px, bx);
      ay = absdiff(py, by);
      return (ax < SPR_R_U) && (ay < SPR_R_U) && (({1'b0, ax} + {1'b0, ay}) < SPR_S_U);
   endfunction

   function automatic logic [5:0] palette(input logic [1:0] k);
      case (k)
         2'd0:    return 6'b11_10_01;
         2'd1:    return 6'b10_11_10;
         2'd2:    return 6'b01_01_11;
         default: return 6'b11_11_11;
      endcase
   endfunction

   // One axis of integration: returns {position, velocity}.
   function automatic logic [COORD_W+VEL_W-1:0] step_axis(
      input logic [COORD_W-1:0]        p,
      input logic signed [VEL_W-1:0]   v,
      input logic signed [VEL_W-1:0]   acc,
      input logic signed [COORD_W+1:0] ext);
      logic signed [COORD_W+1:0] pn;
      logic signed [VEL_W:0]     vs;
      logic signed [VEL_W-1:0]   vn, vo;
      logic [COORD_W-1:0]        po;
      pn = $signed({2'b00, p}) + $signed({{(COORD_W+2-VEL_W){v[VEL_W-1]}}, v});
      vs = $signed({v[VEL_W-1], v}) + $signed({acc[VEL_W-1], acc});
      if (vs > VMAX_S)       vn = VMAX_S[VEL_W-1:0];
      else if (vs < -VMAX_S) vn = VEL_W'(-VMAX_S);
      else                   vn = vs[VEL_W-1:0];
`ifdef NBODY_WRAP_EN
      vo = vn;
      if (pn[COORD_W+1])  po = COORD_W'(pn + ext);
      else if (pn >= ext) po = COORD_W'(pn - ext);
      else                po = pn[COORD_W-1:0];
`else
      if (pn[COORD_W+1]) begin
         po = '0;
         vo = -vn;
      end else if (pn >= ext) begin
         po = COORD_W'(ext - (COORD_W+2)'(1));
         vo = -vn;
      end else begin
         po = pn[COORD_W-1:0];
         vo = vn;
      end
`endif
      return {po, vo};
   endfunction

   assign tick_ok_c = frame_tick & ~pause;

   // Pair force: Manhattan distance banded into 2/1/0, signed per axis from body i toward j.
   always_comb begin
      pd_c  = {1'b0, absdiff(work_x_q[pj_q], work_x_q[pi_q])}
            + {1'b0, absdiff(work_y_q[pj_q], work_y_q[pi_q])};
      pf_c  = (pd_c < NEAR_D) ? VEL_W'(2) : (pd_c < FAR_D) ? VEL_W'(1) : '0;
      psx_c = '0;
      psy_c = '0;
      if (work_x_q[pj_q] > work_x_q[pi_q])      psx_c = pf_c;
      else if (work_x_q[pj_q] < work_x_q[pi_q]) psx_c = -pf_c;
      if (work_y_q[pj_q] > work_y_q[pi_q])      psy_c = pf_c;
      else if (work_y_q[pj_q] < work_y_q[pi_q]) psy_c = -pf_c;
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = 1'b0;
      pi_d      = pi_q;
      pj_d      = pj_q;
      bi_d      = bi_q;
      work_x_d  = work_x_q;
      work_y_d  = work_y_q;
      work_vx_d = work_vx_q;
      work_vy_d = work_vy_q;
      disp_x_d  = disp_x_q;
      disp_y_d  = disp_y_q;
      acc_x_d   = acc_x_q;
      acc_y_d   = acc_y_q;
      overrun_d = tick_ok_c && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (load_en && (32'(load_id) < N_BODIES)) begin
               work_x_d[load_id]  = load_x;
               work_y_d[load_id]  = load_y;
               work_vx_d[load_id] = $signed(load_vx);
               work_vy_d[load_id] = $signed(load_vy);
               disp_x_d[load_id]  = load_x;
               disp_y_d[load_id]  = load_y;
            end
            // A tick coinciding with a load is deferred one cycle so the frame sees the load.
            if (pend_q)         state_d = S_CLEAR;
            else if (tick_ok_c) begin
               if (load_en) pend_d  = 1'b1;
               else         state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            for (int k = 0; k < N_BODIES; k++) begin
               acc_x_d[k] = '0;
               acc_y_d[k] = '0;
            end
            pi_d    = '0;
            pj_d    = ID_W'(1);
            state_d = S_PAIR;
         end
         S_PAIR: begin
            acc_x_d[pi_q] = acc_x_q[pi_q] + psx_c;
            acc_y_d[pi_q] = acc_y_q[pi_q] + psy_c;
            acc_x_d[pj_q] = acc_x_q[pj_q] - psx_c;
            acc_y_d[pj_q] = acc_y_q[pj_q] - psy_c;
            if (pj_q == ID_W'(N_BODIES - 1)) begin
               if (pi_q == ID_W'(N_BODIES - 2)) begin
                  bi_d    = '0;
                  state_d = S_INTEG;
               end else begin
                  pi_d = pi_q + ID_W'(1);
                  pj_d = pi_q + ID_W'(2);
               end
            end else begin
               pj_d = pj_q + ID_W'(1);
            end
         end
         S_INTEG: begin
            {work_x_d[bi_q], work_vx_d[bi_q]} =
               step_axis(work_x_q[bi_q], work_vx_q[bi_q], acc_x_q[bi_q], EXT_X);
            {work_y_d[bi_q], work_vy_d[bi_q]} =
               step_axis(work_y_q[bi_q], work_vy_q[bi_q], acc_y_q[bi_q], EXT_Y);
            if (bi_q == ID_W'(N_BODIES - 1)) state_d = S_COMMIT;
            else                             bi_d    = bi_q + ID_W'(1);
         end
         S_COMMIT: begin
            disp_x_d = work_x_q;
            disp_y_d = work_y_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Renderer: lowest-index covering body wins, blanked outside the active video area.
   always_comb begin
      hit_any_c = 1'b0;
      hit_idx_c = '0;
      for (int k = 0; k < N_BODIES; k++) begin
         if (!hit_any_c && covers(pix_x, pix_y, disp_x_q[k], disp_y_q[k])) begin
            hit_any_c = 1'b1;
            hit_idx_c = ID_W'(k);
         end
      end
      hit_d    = video_active & hit_any_c;
      hit_id_d = hit_d ? hit_idx_c : '0;
      rgb_d    = hit_d ? palette(2'(hit_idx_c)) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pend_q    <= 1'b0;
         pi_q      <= '0;
         pj_q      <= '0;
         bi_q      <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         hit_q     <= 1'b0;
         hit_id_q  <= '0;
         rgb_q     <= '0;
         for (int i = 0; i < N_BODIES; i++) begin
            work_x_q[i]  <= COORD_W'((SCREEN_W / (N_BODIES + 1)) * (i + 1));
            work_y_q[i]  <= (i % 2 == 1) ? COORD_W'(SCREEN_H / 3) : COORD_W'(2 * SCREEN_H / 3);
            disp_x_q[i]  <= COORD_W'((SCREEN_W / (N_BODIES + 1)) * (i + 1));
            disp_y_q[i]  <= (i % 2 == 1) ? COORD_W'(SCREEN_H / 3) : COORD_W'(2 * SCREEN_H / 3);
            work_vx_q[i] <= '0;
            work_vy_q[i] <= '0;
            acc_x_q[i]   <= '0;
            acc_y_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         pi_q      <= pi_d;
         pj_q      <= pj_d;
         bi_q      <= bi_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         hit_q     <= hit_d;
         hit_id_q  <= hit_id_d;
         rgb_q     <= rgb_d;
         work_x_q  <= work_x_d;
         work_y_q  <= work_y_d;
         work_vx_q <= work_vx_d;
         work_vy_q <= work_vy_d;
         disp_x_q  <= disp_x_d;
         disp_y_q  <= disp_y_d;
         acc_x_q   <= acc_x_d;
         acc_y_q   <= acc_y_d;
      end
   end

   assign busy    = busy_q;
   assign overrun = overrun_q;
   assign hit     = hit_q;
   assign hit_id  = hit_id_q;
   assign rgb     = rgb_q;

endmodule

// File: tb/tb_nbody_frame_engine.sv
// Bench for nbody_frame_engine (default N=3): directed frames plus a render scoreboard.
module tb_nbody_frame_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0, pause = 1'b0, load_en = 1'b0, video_active = 1'b0;
   logic [1:0] load_id = '0;
   logic [9:0] load_x = '0, load_y = '0, pix_x = '0, pix_y = '0;
   logic [7:0] load_vx = '0, load_vy = '0;
   logic       busy, overrun, hit;
   logic [1:0] hit_id;
   logic [5:0] rgb;

   int   checks = 0;
   int   errors = 0;
   logic pix_vld = 1'b0;
   int   exp_q[$];

   nbody_frame_engine dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause),
      .load_en(load_en), .load_id(load_id), .load_x(load_x), .load_y(load_y),
      .load_vx(load_vx), .load_vy(load_vy), .pix_x(pix_x), .pix_y(pix_y),
      .video_active(video_active), .busy(busy), .overrun(overrun),
      .hit(hit), .hit_id(hit_id), .rgb(rgb)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic load_body(input int id, input int x, input int y, input int vx, input int vy);
      load_en = 1'b1;
      load_id = 2'(id);
      load_x  = 10'(x);
      load_y  = 10'(y);
      load_vx = 8'(vx);
      load_vy = 8'(vy);
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (busy) chk({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic run_frame(input string name);
      int n = 0;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk({name, "_busy_cycles"}, n, 8);
   endtask

   task automatic chk_body(input string name, input int id, input int x, input int y,
                           input int vx, input int vy);
      chk($sformatf("%s_b%0d_x", name, id),  int'(dut.disp_x_q[id]), x);
      chk($sformatf("%s_b%0d_y", name, id),  int'(dut.disp_y_q[id]), y);
      chk($sformatf("%s_b%0d_vx", name, id), int'($signed(dut.work_vx_q[id])), vx);
      chk($sformatf("%s_b%0d_vy", name, id), int'($signed(dut.work_vy_q[id])), vy);
   endtask

   task automatic pix(input int x, input int y, input logic va,
                      input logic e_hit, input logic [1:0] e_id, input logic [5:0] e_rgb);
      pix_x        = 10'(x);
      pix_y        = 10'(y);
      video_active = va;
      pix_vld      = 1'b1;
      exp_q.push_back(int'({e_hit, e_id, e_rgb}));
      @(negedge clk);
      pix_vld      = 1'b0;
   endtask

   // Render monitor: a pixel presented before a rising edge is checked at the following falling edge.
   task automatic render_monitor();
      logic v;
      int   e;
      forever begin
         @(posedge clk);
         v = pix_vld;
         @(negedge clk);
         if (v) begin
            if (exp_q.size() == 0) chk("render_queue_underflow", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("render_hit_id_rgb", int'({hit, hit_id, rgb}), e);
            end
         end
      end
   endtask

   initial begin
      fork
         render_monitor();
      join_none

      // Reset
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_hit", int'(hit), 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_hit_id", int'(hit_id), 0);
      reset = 1'b0;
      @(negedge clk);
      chk_body("rst", 0, 160, 320, 0, 0);
      chk_body("rst", 1, 320, 160, 0, 0);
      chk_body("rst", 2, 480, 320, 0, 0);
      pix(320, 160, 1'b1, 1'b1, 2'd1, 6'b10_11_10);

      // Far-band force (f=1) with overrun tick and ignored load during busy
      load_body(0, 200, 100, 0, 0);
      load_body(1, 210, 150, 0, 0);
      load_body(2, 600, 400, 0, 0);
      frame_tick = 1'b1;
      @(negedge clk);
      chk("ovr_busy_up", int'(busy), 1);
      load_en = 1'b1; load_id = 2'd0; load_x = 10'd50; load_y = 10'd50;
      load_vx = 8'd0; load_vy = 8'd0;
      @(negedge clk);
      frame_tick = 1'b0;
      load_en = 1'b0;
      chk("ovr_pulse", int'(overrun), 1);
      @(negedge clk);
      chk("ovr_pulse_end", int'(overrun), 0);
      wait_idle("ovr");
      chk_body("far", 0, 200, 100, 1, 1);
      chk_body("far", 1, 210, 150, -1, -1);
      chk_body("far", 2, 600, 400, 0, 0);

      // Paused tick is ignored
      pause = 1'b1;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      pause = 1'b0;
      chk("pause_busy0", int'(busy), 0);
      @(negedge clk);
      chk("pause_busy1", int'(busy), 0);
      chk_body("pause", 0, 200, 100, 1, 1);

      // Near-band force; load coincident with tick delays the start by one cycle
      load_body(1, 130, 200, 0, 0);
      load_body(2, 600, 20, 0, 0);
      load_en = 1'b1; load_id = 2'd0; load_x = 10'd100; load_y = 10'd200;
      load_vx = 8'd0; load_vy = 8'd0;
      frame_tick = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      frame_tick = 1'b0;
      chk("coinc_delay", int'(busy), 0);
      @(negedge clk);
      chk("coinc_start", int'(busy), 1);
      wait_idle("coinc");
      chk_body("near1", 0, 100, 200, 2, 0);
      chk_body("near1", 1, 130, 200, -2, 0);
      run_frame("near2");
      chk_body("near2", 0, 102, 200, 4, 0);
      chk_body("near2", 1, 128, 200, -4, 0);

      // Velocity saturation at VMAX=15
      load_body(0, 100, 200, 14, 0);
      load_body(1, 130, 200, 0, 0);
      load_body(2, 600, 20, 0, 0);
      run_frame("sat1");
      chk_body("sat1", 0, 114, 200, 15, 0);
      run_frame("sat2");
      chk_body("sat2", 0, 129, 200, 15, 0);
      chk_body("sat2", 1, 128, 200, -4, 0);

      // Screen edges: left x and bottom y
      load_body(0, 1, 240, -3, 0);
      load_body(1, 600, 20, 0, 0);
      load_body(2, 200, 478, 0, 5);
      run_frame("edge");
`ifdef NBODY_WRAP_EN
      chk_body("edge", 0, 638, 240, -3, 0);
      chk_body("edge", 2, 200, 3, 0, 5);
`else
      chk_body("edge", 0, 0, 240, 3, 0);
      chk_body("edge", 2, 200, 479, 0, -5);
`endif

      // Renderer
      load_body(0, 320, 240, 0, 0);
      load_body(1, 600, 20, 0, 0);
      load_body(2, 20, 20, 0, 0);
      pix(330, 250, 1'b1, 1'b1, 2'd0, 6'b11_10_01);
      pix(340, 240, 1'b1, 1'b0, 2'd0, 6'b00_00_00);
      pix(334, 250, 1'b1, 1'b1, 2'd0, 6'b11_10_01);
      pix(335, 250, 1'b1, 1'b0, 2'd0, 6'b00_00_00);
      pix(301, 240, 1'b1, 1'b1, 2'd0, 6'b11_10_01);
      pix(300, 240, 1'b1, 1'b0, 2'd0, 6'b00_00_00);
      pix(605, 25, 1'b1, 1'b1, 2'd1, 6'b10_11_10);
      pix(20, 20, 1'b1, 1'b1, 2'd2, 6'b01_01_11);
      pix(0, 0, 1'b1, 1'b0, 2'd0, 6'b00_00_00);
      pix(330, 250, 1'b0, 1'b0, 2'd0, 6'b00_00_00);
      load_body(1, 320, 240, 0, 0);
      pix(320, 240, 1'b1, 1'b1, 2'd0, 6'b11_10_01);
      load_body(0, 100, 100, 0, 0);
      pix(320, 240, 1'b1, 1'b1, 2'd1, 6'b10_11_10);

      video_active = 1'b0;
      repeat (3) @(negedge clk);
      chk("render_queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
